// File: rtl/cpu_ctrl_pkg.sv
// Shared control-bundle widths, field positions, stage records and bubble constants
// for the EX/MEM/WB control pipeline.
package cpu_ctrl_pkg;

  localparam int WB_W   = 2;
  localparam int MEM_W  = 3;
  localparam int CALC_W = 4;
  localparam int REG_W  = 5;

  // Write-back group {regWrite, memToReg}
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // Memory-access group {branch, memRead, memWrite}
  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;

  // Calculation group {regDst, aluOp[1:0], aluSrc}
  localparam int CALC_REG_DST   = 3;
  localparam int CALC_ALU_OP_HI = 2;
  localparam int CALC_ALU_OP_LO = 1;
  localparam int CALC_ALU_SRC   = 0;

  localparam logic [WB_W-1:0]   WB_BUBBLE   = '0;
  localparam logic [MEM_W-1:0]  MEM_BUBBLE  = '0;
  localparam logic [CALC_W-1:0] CALC_BUBBLE = '0;

  typedef struct packed {
    logic              valid;
    logic [WB_W-1:0]   wb;
    logic [MEM_W-1:0]  mem;
    logic [CALC_W-1:0] calc;
    logic [REG_W-1:0]  dest;
  } ex_stage_t;

  typedef struct packed {
    logic             valid;
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic             zero;
    logic [REG_W-1:0] dest;
  } mem_stage_t;

  typedef struct packed {
    logic             valid;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] dest;
  } wb_stage_t;

  localparam ex_stage_t  EX_STAGE_BUBBLE  = '0;
  localparam mem_stage_t MEM_STAGE_BUBBLE = '0;
  localparam wb_stage_t  WB_STAGE_BUBBLE  = '0;

  // Builds the EX record from decoder outputs. Fields that only matter when the
  // instruction writes a register are cleared otherwise, so decoder don't-cares
  // never reach state.
  function automatic ex_stage_t capture_ex(
    input logic              valid,
    input logic [WB_W-1:0]   wb,
    input logic [MEM_W-1:0]  mem,
    input logic [CALC_W-1:0] calc,
    input logic [REG_W-1:0]  rt,
    input logic [REG_W-1:0]  rd
  );
    ex_stage_t s;
    s = EX_STAGE_BUBBLE;
    if (valid) begin
      s.valid                = 1'b1;
      s.wb[WB_REG_WRITE]     = wb[WB_REG_WRITE];
      s.wb[WB_MEM_TO_REG]    = wb[WB_REG_WRITE] & wb[WB_MEM_TO_REG];
      s.mem                  = mem;
      s.calc                 = calc;
      s.calc[CALC_REG_DST]   = wb[WB_REG_WRITE] & calc[CALC_REG_DST];
      s.dest                 = s.calc[CALC_REG_DST] ? rd : rt;
    end
    return s;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags a decode-stage instruction that reads the register
// a load currently in EX is about to produce.
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             load_use
);

  logic dest_nonzero;
  logic src_match;

  // r0 is hardwired, so a load targeting it never creates a dependency
  assign dest_nonzero = (ex_dest != '0);
  assign src_match    = (ex_dest == id_rs) || (ex_dest == id_rt);
  assign load_use     = ex_valid & ex_mem_read & dest_nonzero & id_valid & src_match;

endmodule

// File: rtl/control_pipeline.sv
// EX/MEM/WB control-signal pipeline with branch flush and external freeze.
// Define LOAD_USE_STALL_EN to add load-use interlocking through hazard_detect.
module control_pipeline
  import cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idValid,
  input  logic [WB_W-1:0]   idWriteBack,
  input  logic [MEM_W-1:0]  idMemAccess,
  input  logic [CALC_W-1:0] idCalc,
  input  logic [REG_W-1:0]  idRs,
  input  logic [REG_W-1:0]  idRt,
  input  logic [REG_W-1:0]  idRd,
  input  logic              exZero,
  input  logic              extStall,
  output logic [CALC_W-1:0] exCalc,
  output logic              exValid,
  output logic [MEM_W-1:0]  memAccess,
  output logic              memValid,
  output logic [WB_W-1:0]   wbWriteBack,
  output logic [REG_W-1:0]  wbDest,
  output logic              wbValid,
  output logic              pcSrc,
  output logic              flush,
  output logic              idStall
);

  ex_stage_t  ex_q,  ex_d;
  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q,  wb_d;
  logic       load_use;
  logic       branch_taken;

`ifdef LOAD_USE_STALL_EN
  hazard_detect u_hazard_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem[MEM_READ]),
    .ex_dest     (ex_q.dest),
    .id_valid    (idValid),
    .id_rs       (idRs),
    .id_rt       (idRt),
    .load_use    (load_use)
  );
`else
  // Without interlocking the source register field has no consumer here
  logic hazard_unused;
  assign hazard_unused = ^idRs;
  assign load_use      = 1'b0;
`endif

  // Decided entirely from MEM state, so it stays valid while the pipe is frozen
  assign branch_taken = mem_q.valid & mem_q.mem[MEM_BRANCH] & mem_q.zero;

  always_comb begin
    ex_d       = capture_ex(idValid, idWriteBack, idMemAccess, idCalc, idRt, idRd);
    mem_d.valid = ex_q.valid;
    mem_d.wb    = ex_q.wb;
    mem_d.mem   = ex_q.mem;
    mem_d.zero  = exZero;
    mem_d.dest  = ex_q.dest;
    wb_d.valid  = mem_q.valid;
    wb_d.wb     = mem_q.wb;
    wb_d.dest   = mem_q.dest;
    if (branch_taken) begin
      // The branch itself retires; the two younger instructions are squashed
      ex_d    = EX_STAGE_BUBBLE;
      mem_d   = MEM_STAGE_BUBBLE;
      wb_d.wb = WB_BUBBLE;
    end else if (load_use) begin
      ex_d = EX_STAGE_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= EX_STAGE_BUBBLE;
      mem_q <= MEM_STAGE_BUBBLE;
      wb_q  <= WB_STAGE_BUBBLE;
    end else if (!extStall) begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign exCalc      = ex_q.calc;
  assign exValid     = ex_q.valid;
  assign memAccess   = mem_q.mem;
  assign memValid    = mem_q.valid;
  assign wbWriteBack = wb_q.wb;
  assign wbDest      = wb_q.dest;
  assign wbValid     = wb_q.valid;
  assign pcSrc       = branch_taken;
  assign flush       = branch_taken;
  // A freeze outranks a flush, which outranks a load-use hold
  assign idStall     = rst_n & (extStall | (load_use & ~branch_taken));

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: directed instruction sequences push the
// expected {wbWriteBack, wbDest} of every retiring instruction; a monitor checks WB.
module tb_control_pipeline;
  import cpu_ctrl_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              idValid;
  logic [WB_W-1:0]   idWriteBack;
  logic [MEM_W-1:0]  idMemAccess;
  logic [CALC_W-1:0] idCalc;
  logic [REG_W-1:0]  idRs, idRt, idRd;
  logic              exZero;
  logic              extStall;
  logic [CALC_W-1:0] exCalc;
  logic              exValid;
  logic [MEM_W-1:0]  memAccess;
  logic              memValid;
  logic [WB_W-1:0]   wbWriteBack;
  logic [REG_W-1:0]  wbDest;
  logic              wbValid;
  logic              pcSrc, flush, idStall;

  int tests;
  int failures;
  logic [6:0] exp_q[$];
  logic [6:0] exp_rec;
  logic       wb_adv;

  control_pipeline dut (
    .clk(clk), .rst_n(rst_n), .idValid(idValid), .idWriteBack(idWriteBack),
    .idMemAccess(idMemAccess), .idCalc(idCalc), .idRs(idRs), .idRt(idRt), .idRd(idRd),
    .exZero(exZero), .extStall(extStall), .exCalc(exCalc), .exValid(exValid),
    .memAccess(memAccess), .memValid(memValid), .wbWriteBack(wbWriteBack),
    .wbDest(wbDest), .wbValid(wbValid), .pcSrc(pcSrc), .flush(flush), .idStall(idStall)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Checking helpers
  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // WB only takes new content on an edge where the pipe was not frozen
  always @(posedge clk) wb_adv <= rst_n && !extStall;

  always @(negedge clk) begin
    if (rst_n && wbValid && wb_adv) begin
      if (exp_q.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL wb_unexpected: got %0h expected none", {wbWriteBack, wbDest});
      end else begin
        exp_rec = exp_q.pop_front();
        check("wb_record", {25'd0, wbWriteBack, wbDest}, {25'd0, exp_rec});
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [1:0] wb, input logic [2:0] acc,
                        input logic [3:0] calc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    idValid     = v;
    idWriteBack = wb;
    idMemAccess = acc;
    idCalc      = calc;
    idRs        = rs;
    idRt        = rt;
    idRd        = rd;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0);
    repeat (n) tick();
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    wb_adv   = 1'b0;
    rst_n    = 1'b0;
    exZero   = 1'b0;
    extStall = 1'b1;
    set_id(1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0);

    // Reset state, including idStall masked while a freeze request is present
    #12;
    check("rst_id_stall", idStall, 0);
    check("rst_pc_src", pcSrc, 0);
    check("rst_flush", flush, 0);
    check("rst_ex_valid", exValid, 0);
    check("rst_mem_valid", memValid, 0);
    check("rst_wb_valid", wbValid, 0);
    check("rst_ex_calc", exCalc, 0);
    extStall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ex_valid", exValid, 0);

    // R-format: rd=9 retires with regWrite
    set_id(1'b1, 2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd9);
    exp_q.push_back({2'b10, 5'd9});
    tick();
    check("rfmt_ex_calc", exCalc, 4'b1100);
    check("rfmt_ex_valid", exValid, 1);
    idle(1);
    check("rfmt_mem_valid", memValid, 1);
    check("rfmt_mem_access", memAccess, 3'b000);
    idle(1);
    check("rfmt_wb_dest", wbDest, 9);
    idle(2);

    // Store with don't-care memToReg/regDst set high: both must be cleared
    set_id(1'b1, 2'b01, 3'b001, 4'b1001, 5'd3, 5'd4, 5'd7);
    exp_q.push_back({2'b00, 5'd4});
    tick();
    check("store_ex_calc", exCalc, 4'b0001);
    idle(1);
    check("store_mem_access", memAccess, 3'b001);
    idle(3);

    // Load-use: lw r5 in EX, consumer reads r5
    set_id(1'b1, 2'b11, 3'b010, 4'b0001, 5'd1, 5'd5, 5'd0);
    exp_q.push_back({2'b11, 5'd5});
    tick();
    set_id(1'b1, 2'b10, 3'b000, 4'b1100, 5'd5, 5'd6, 5'd10);
    exp_q.push_back({2'b10, 5'd10});
    #1;
`ifdef LOAD_USE_STALL_EN
    check("lu_stall_on", idStall, 1);
    tick();
    check("lu_bubble_ex_valid", exValid, 0);
    check("lu_stall_off", idStall, 0);
    check("lu_lw_in_mem", memAccess, 3'b010);
    tick();
`else
    check("lu_no_stall", idStall, 0);
    tick();
`endif
    check("lu_consumer_ex_valid", exValid, 1);
    check("lu_consumer_ex_calc", exCalc, 4'b1100);
    idle(4);

    // Taken branch; the lw/consumer pair behind it must not stall a flush
    set_id(1'b1, 2'b00, 3'b100, 4'b0010, 5'd1, 5'd2, 5'd3);
    exp_q.push_back({2'b00, 5'd2});
    tick();
    exZero = 1'b1;
    set_id(1'b1, 2'b11, 3'b010, 4'b0001, 5'd0, 5'd7, 5'd0);
    #1;
    check("br_pc_src_ex", pcSrc, 0);
    tick();
    exZero = 1'b0;
    set_id(1'b1, 2'b10, 3'b000, 4'b1100, 5'd7, 5'd0, 5'd12);
    #1;
    check("br_pc_src", pcSrc, 1);
    check("br_flush", flush, 1);
    check("br_flush_beats_lu", idStall, 0);
    tick();
    check("br_ex_bubble", exValid, 0);
    check("br_mem_bubble", memValid, 0);
    check("br_pc_src_clear", pcSrc, 0);
    check("br_wb_valid", wbValid, 1);
    check("br_wb_regwrite", wbWriteBack, 2'b00);
    idle(4);

    // External freeze for three edges with E in MEM and F in EX
    set_id(1'b1, 2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd13);
    exp_q.push_back({2'b10, 5'd13});
    tick();
    set_id(1'b1, 2'b10, 3'b000, 4'b1010, 5'd1, 5'd2, 5'd14);
    exp_q.push_back({2'b10, 5'd14});
    tick();
    set_id(1'b1, 2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd15);
    exp_q.push_back({2'b10, 5'd15});
    extStall = 1'b1;
    #1;
    check("frz_id_stall", idStall, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_ex_calc", exCalc, 4'b1010);
      check("frz_ex_valid", exValid, 1);
      check("frz_mem_valid", memValid, 1);
      check("frz_wb_valid", wbValid, 0);
      check("frz_id_stall_held", idStall, 1);
    end
    extStall = 1'b0;
    tick();
    check("frz_release_ex_calc", exCalc, 4'b1100);
    check("frz_release_wb_dest", wbDest, 13);
    idle(4);

    // Taken branch frozen in MEM: pcSrc holds until release
    set_id(1'b1, 2'b00, 3'b100, 4'b0010, 5'd1, 5'd8, 5'd3);
    exp_q.push_back({2'b00, 5'd8});
    tick();
    exZero = 1'b1;
    set_id(1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0);
    tick();
    exZero   = 1'b0;
    extStall = 1'b1;
    set_id(1'b1, 2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd20);
    #1;
    check("brfrz_pc_src", pcSrc, 1);
    check("brfrz_id_stall", idStall, 1);
    repeat (2) begin
      tick();
      check("brfrz_pc_src_held", pcSrc, 1);
      check("brfrz_mem_valid", memValid, 1);
    end
    extStall = 1'b0;
    #1;
    check("brfrz_release_id_stall", idStall, 0);
    check("brfrz_release_flush", flush, 1);
    tick();
    check("brfrz_pc_src_clear", pcSrc, 0);
    check("brfrz_ex_bubble", exValid, 0);
    check("brfrz_wb_regwrite", wbWriteBack, 2'b00);
    idle(4);

    // Asynchronous reset while a taken branch sits in MEM
    set_id(1'b1, 2'b00, 3'b100, 4'b0010, 5'd1, 5'd9, 5'd3);
    tick();
    exZero = 1'b1;
    set_id(1'b1, 2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd21);
    tick();
    exZero = 1'b0;
    idle(0);
    check("arst_pre_pc_src", pcSrc, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc_src", pcSrc, 0);
    check("arst_flush", flush, 0);
    check("arst_mem_valid", memValid, 0);
    check("arst_ex_valid", exValid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_post_ex_valid", exValid, 0);
    check("arst_post_mem_valid", memValid, 0);
    check("arst_post_wb_valid", wbValid, 0);
    idle(4);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
